// File: rtl/alu_control_seq.sv
// Registered ALU control decoder: {ALUOp, Funct} in over valid/ready, {Operation, Bnegate}
// out of a one-entry register, with a multiply stall window and a saturating illegal-op count.
module alu_control_seq #(
  parameter int FUNCT_W     = 4,
  parameter int MUL_LATENCY = 4,
  parameter int ILL_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           ALUOp,
  input  logic [FUNCT_W-1:0]   Funct,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           Operation,
  output logic                 Bnegate,
  output logic                 illegal,
  output logic                 mul_busy,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam int CNT_W = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       bneg;
    logic       ill;
  } dec_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_t             dec;
  logic             rdy_int, accept, is_mul;

  // Decode table; every path assigns every field.
  always_comb begin
    dec = '{op: 4'b0010, bneg: 1'b0, ill: 1'b0};
    unique case (ALUOp)
      2'b00: dec = '{op: 4'b0010, bneg: 1'b0, ill: 1'b0};
      2'b01: dec = '{op: 4'b0010, bneg: 1'b1, ill: 1'b0};
      2'b11: dec = '{op: 4'b0100, bneg: 1'b0, ill: 1'b0};
      default: begin
        if ((Funct >> 4) != '0) begin
          dec = '{op: 4'b0000, bneg: 1'b0, ill: 1'b1};
        end else begin
          case (Funct[3:0])
            4'b0010: dec = '{op: 4'b0010, bneg: 1'b0, ill: 1'b0};
            4'b1010: dec = '{op: 4'b0010, bneg: 1'b1, ill: 1'b0};
            4'b0000: dec = '{op: 4'b0000, bneg: 1'b0, ill: 1'b0};
            4'b0001: dec = '{op: 4'b0001, bneg: 1'b0, ill: 1'b0};
            4'b0011: dec = '{op: 4'b0011, bneg: 1'b0, ill: 1'b0};
            4'b0110: dec = '{op: 4'b0110, bneg: 1'b0, ill: 1'b0};
            4'b0101: dec = '{op: 4'b0101, bneg: 1'b0, ill: 1'b0};
            default: dec = '{op: 4'b0000, bneg: 1'b0, ill: 1'b1};
          endcase
        end
      end
    endcase
  end

  // Reset only masks the visible ready; internal accept is irrelevant while flops are held.
  assign rdy_int  = (state_q == IDLE) && (!out_valid || out_ready);
  assign in_ready = reset_n && rdy_int;
  assign accept   = in_valid && rdy_int;
  assign is_mul   = (ALUOp == 2'b11);
  assign mul_busy = (state_q == MUL_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mul && (MUL_LATENCY > 0)) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_W'(MUL_LATENCY);
        end
      end
      MUL_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-entry output register: reload on accept, clear on drain without accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      Operation <= '0;
      Bnegate   <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      Operation <= dec.op;
      Bnegate   <= dec.bneg;
      illegal   <= dec.ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ill_count <= '0;
    end else if (accept && dec.ill && (ill_count != '1)) begin
      ill_count <= ill_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed table, multi-cycle corner sequences, and random traffic
// checked every cycle against a transaction-level model.
module tb_alu_control_seq;
  localparam int FUNCT_W = 4;
  localparam int LAT     = 4;
  localparam int ICW     = 8;
  localparam int ICMAX   = (1 << ICW) - 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [1:0]     ALUOp;
  logic [FUNCT_W-1:0] Funct;
  logic [3:0]     Operation;
  logic           Bnegate, illegal, mul_busy;
  logic [ICW-1:0] ill_count;

  alu_control_seq #(.FUNCT_W(FUNCT_W), .MUL_LATENCY(LAT), .ILL_CNT_W(ICW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .out_valid(out_valid), .out_ready(out_ready),
    .Operation(Operation), .Bnegate(Bnegate), .illegal(illegal),
    .mul_busy(mul_busy), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: pending output entry, remaining busy cycles, illegal count
  bit       m_ov;
  bit [3:0] m_op;
  bit       m_bn, m_il;
  int       m_busy_left;
  int       m_cnt;
  bit       s_in_ready, s_busy;

  typedef struct {
    bit [1:0] aluop;
    bit [3:0] funct;
    bit [3:0] op;
    bit       bn;
    bit       il;
  } vec_t;
  vec_t tbl[12];

  int legal_f[7]  = '{2, 10, 0, 1, 3, 6, 5};
  int legal_op[7] = '{2, 2, 0, 1, 3, 6, 5};
  int legal_bn[7] = '{0, 1, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic ref_dec(input bit [1:0] a, input bit [3:0] f,
                         output bit [3:0] op, output bit bn, output bit il);
    op = 4'd0; bn = 1'b0; il = 1'b0;
    if (a == 2'd0) op = 4'd2;
    else if (a == 2'd1) begin op = 4'd2; bn = 1'b1; end
    else if (a == 2'd3) op = 4'd4;
    else begin
      il = 1'b1;
      for (int i = 0; i < 7; i++)
        if (int'(f) == legal_f[i]) begin
          op = 4'(legal_op[i]); bn = legal_bn[i][0]; il = 1'b0;
        end
    end
  endtask

  function automatic bit m_in_ready();
    return (m_busy_left == 0) && (!m_ov || out_ready);
  endfunction

  task automatic m_reset();
    m_ov = 0; m_op = 0; m_bn = 0; m_il = 0; m_busy_left = 0; m_cnt = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit acc;
    @(negedge clk);
    s_in_ready = in_ready;
    s_busy     = mul_busy;
    chk("in_ready", int'(in_ready), int'(m_in_ready()));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("mul_busy", int'(mul_busy), int'(m_busy_left > 0));
    chk("ill_count", int'(ill_count), m_cnt);
    if (m_ov) begin
      chk("Operation", int'(Operation), int'(m_op));
      chk("Bnegate", int'(Bnegate), int'(m_bn));
      chk("illegal", int'(illegal), int'(m_il));
    end
    acc = in_valid && m_in_ready();
    @(posedge clk);
    if (acc) begin
      ref_dec(ALUOp, Funct, m_op, m_bn, m_il);
      m_ov = 1;
      if (m_il && m_cnt < ICMAX) m_cnt++;
      if (ALUOp == 2'd3 && LAT > 0) m_busy_left = LAT;
    end else begin
      if (out_ready) m_ov = 0;
      if (m_busy_left > 0) m_busy_left--;
    end
    #1;
  endtask

  task automatic chk_out(input string name, input bit [3:0] op, input bit bn, input bit il);
    chk({name, ".valid"}, int'(out_valid), 1);
    chk({name, ".op"}, int'(Operation), int'(op));
    chk({name, ".bneg"}, int'(Bnegate), int'(bn));
    chk({name, ".ill"}, int'(illegal), int'(il));
  endtask

  initial begin
    tbl[0]  = '{2'b10, 4'b0010, 4'b0010, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 4'b1010, 4'b0010, 1'b1, 1'b0};
    tbl[2]  = '{2'b10, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 4'b0001, 4'b0001, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 4'b0011, 4'b0011, 1'b0, 1'b0};
    tbl[5]  = '{2'b10, 4'b0110, 4'b0110, 1'b0, 1'b0};
    tbl[6]  = '{2'b10, 4'b0101, 4'b0101, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 4'b0111, 4'b0010, 1'b0, 1'b0};
    tbl[8]  = '{2'b01, 4'b1111, 4'b0010, 1'b1, 1'b0};
    tbl[9]  = '{2'b10, 4'b0111, 4'b0000, 1'b0, 1'b1};
    tbl[10] = '{2'b10, 4'b1111, 4'b0000, 1'b0, 1'b1};
    tbl[11] = '{2'b10, 4'b0100, 4'b0000, 1'b0, 1'b1};

    // Reset with a MUL held on the input
    m_reset();
    reset_n = 1'b0; in_valid = 1'b1; ALUOp = 2'b11; Funct = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", int'(in_ready), 0);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.op", int'(Operation), 0);
    chk("rst.bneg", int'(Bnegate), 0);
    chk("rst.ill", int'(illegal), 0);
    chk("rst.mul_busy", int'(mul_busy), 0);
    chk("rst.ill_count", int'(ill_count), 0);
    reset_n = 1'b1;
    step();
    chk("rst.accept", int'(s_in_ready), 1);
    chk_out("mul0", 4'b0100, 1'b0, 1'b0);

    // Second MUL offered continuously: stalled for LAT cycles, accepted on the next
    for (int i = 1; i <= LAT; i++) begin
      step();
      chk("mulwait.busy", int'(s_busy), 1);
      chk("mulwait.in_ready", int'(s_in_ready), 0);
    end
    step();
    chk("mul1.accept", int'(s_in_ready), 1);
    chk("mul1.busy_at_accept", int'(s_busy), 0);
    in_valid = 1'b0;
    repeat (LAT + 1) step();

    // Decode table streamed at full throughput
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ALUOp = tbl[i].aluop; Funct = tbl[i].funct;
      step();
      chk($sformatf("tbl%0d.accept", i), int'(s_in_ready), 1);
      chk_out($sformatf("tbl%0d", i), tbl[i].op, tbl[i].bn, tbl[i].il);
    end

    // Back-pressure: entry held stable, new one accepted as out_ready rises
    ALUOp = 2'b01; Funct = '0;
    step();
    ALUOp = 2'b00; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.in_ready", int'(s_in_ready), 0);
      chk_out("hold", 4'b0010, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk("hold.release_accept", int'(s_in_ready), 1);
    chk_out("after_hold", 4'b0010, 1'b0, 1'b0);

    // Illegal count saturation
    ALUOp = 2'b10; Funct = 4'b0111;
    for (int i = 0; i < 300; i++) begin
      step();
      chk("ill.illegal", int'(illegal), 1);
    end
    chk("ill.saturated", int'(ill_count), ICMAX);
    step();
    chk("ill.stays", int'(ill_count), ICMAX);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ALUOp     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) Funct = 4'(legal_f[$urandom_range(0, 6)]);
      else Funct = 4'($urandom_range(0, 15));
      step();
    end

    // Reset in the middle of a multiply (cnt==2)
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 2) step();
    in_valid = 1'b1; ALUOp = 2'b11;
    step();
    chk("mid.accept", int'(s_in_ready), 1);
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("mid.busy_before", int'(mul_busy), 1);
    chk("mid.ov_before", int'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid.busy_rst", int'(mul_busy), 0);
    chk("mid.ov_rst", int'(out_valid), 0);
    m_reset();
    #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mid.in_ready_after", int'(s_in_ready), 1);
    chk("mid.ov_after", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, parametrised successor to the combinational ALU control decoder.
- Accepts {ALUOp, Funct} from the control unit over a valid/ready handshake and presents {Operation, Bnegate} from a one-entry output register.
- Stalls new issues while an iterative multiply is in flight, flags undefined Funct codes, and keeps a saturating illegal-op counter.
- Sits between the main control unit and the 24-bit ALU / multiplier.

Parameters:
- FUNCT_W, 4, width of the Funct field; bits above [3] must be zero for a legal R-format code.
- MUL_LATENCY, 4, cycles the multiplier is busy after a MUL issue; 0 means no stall.
- ILL_CNT_W, 8, width of the illegal-op counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALUOp/Funct are valid.
- in_ready  output  1  block can accept an entry this cycle.
- ALUOp  input  2  operation class from the control unit.
- Funct  input  FUNCT_W  R-format function code.
- out_valid  output  1  Operation/Bnegate hold a decoded entry.
- out_ready  input  1  consumer takes the entry this cycle.
- Operation  output  4  ALU operation select; upper bit is 0 for all defined ops.
- Bnegate  output  1  invert B and carry-in (subtract).
- illegal  output  1  current output entry came from an undefined Funct.
- mul_busy  output  1  multiplier occupied (state MUL_WAIT).
- ill_count  output  ILL_CNT_W  saturating count of illegal entries accepted.

Behaviour:
- Reset (asynchronous, reset_n low):
  - out_valid=0, Operation=0, Bnegate=0, illegal=0.
  - mul_busy=0, ill_count=0, state=IDLE, cnt=0.
  - Reset asserted mid-multiply aborts the multiply. No output is retained.
- Decode table (combinational; result registered on accept):
  - ALUOp=00 -> Operation 0010, Bnegate 0 (lw/sw add).
  - ALUOp=01 -> 0010, Bnegate 1 (beq/bne subtract).
  - ALUOp=11 -> 0100, Bnegate 0 (MUL).
  - ALUOp=10 -> by Funct:
    - 0010 -> 0010/0 (add); 1010 -> 0010/1 (sub).
    - 0000 -> 0000/0 (and); 0001 -> 0001/0 (or).
    - 0011 -> 0011/0 (slt); 0110 -> 0110/0 (sll); 0101 -> 0101/0 (xor).
  - Any other Funct, or any nonzero Funct bit above [3], with ALUOp=10 -> Operation 0000, Bnegate 0, illegal 1.
  - Funct is ignored for ALUOp != 10.
  - The decoder holds no state, so no stale value can be retained.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready. On accept, the output register loads at the next edge and out_valid=1.
  - Latency: 1 cycle from accept to out_valid.
  - Output drain = out_valid && out_ready.
  - Drain and accept in the same cycle: register reloads and out_valid stays 1 (full throughput, one op per cycle).
  - Drain without accept: out_valid -> 0.
  - While out_valid && !out_ready, Operation, Bnegate and illegal are held stable.
  - in_valid is ignored when in_ready=0.
- FSM states IDLE, MUL_WAIT:
  - IDLE -> MUL_WAIT on accept of ALUOp=11 when MUL_LATENCY>0; load cnt=MUL_LATENCY.
  - MUL_WAIT: cnt decrements each cycle. When cnt==1, go to IDLE at the next edge.
  - mul_busy = (state==MUL_WAIT).
  - With MUL_LATENCY=0, MUL behaves like any other op and MUL_WAIT is never entered.
  - Back-to-back MULs: the second is accepted only after return to IDLE.
  - The MUL entry itself is presented on out_valid normally; it drains independently of the stall.
- ill_count:
  - Increments by 1 on every accept of an illegal entry.
  - Saturates at all-ones; no wrap.
- No latches: all decode paths assign both outputs.

Test Plan:
- Reset with in_valid=1, ALUOp=11 held -> during reset all outputs 0 and in_ready=0; first edge after release accepts it: Operation=0100, Bnegate=0, out_valid=1.
- Stream ALUOp=10 with Funct 0010,1010,0000,0001,0011,0110,0101, out_ready=1 -> one output per cycle, 1-cycle latency: 0010/0, 0010/1, 0000/0, 0001/0, 0011/0, 0110/0, 0101/0, illegal=0 throughout.
- MUL (ALUOp=11) accepted at cycle T, MUL_LATENCY=4 -> mul_busy=1 on cycles T+1..T+4; in_ready=0 on cycles T+1..T+4; a second MUL is offered continuously and accepted at T+5.
- Hold out_ready=0 for 3 cycles with ALUOp=01 in the register -> Operation=0010, Bnegate=1 stable; in_ready=0; a new entry is accepted in the cycle out_ready rises.
- ALUOp=10, Funct=0111 accepted 300 times (ILL_CNT_W=8) -> each output is 0000/0 with illegal=1; ill_count=255 and stays there.
- Assert reset_n low in MUL_WAIT (cnt=2) -> mul_busy and out_valid drop immediately; after release, in_ready=1 at the first edge.
